// File: rtl/ex_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ex_mdu_ctrl
// Description : MIPS-style multiply/divide unit controller with HI/LO.
//               Single-cycle multiply and HI/LO moves. 32-iteration restoring
//               divide. Optional early-out on divide by zero, enabled by the
//               macro MDU_DIV_ZERO_EARLY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mdu_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  output logic        busy,
  output logic        out_valid,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ONE  = 2'd1;
  localparam logic [1:0] c_DIV  = 2'd2;
  localparam logic [1:0] c_FIX  = 2'd3;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [7:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_onehot;
  logic        w_accept;
  logic        w_is_div;
  logic        w_early;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [63:0] w_ma;
  logic [63:0] w_mb;
  logic [63:0] w_prod;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign w_onehot = (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
  assign in_ready = (r_state == c_IDLE) & ~cancel;
  assign w_accept = in_valid & in_ready & w_onehot;
  assign w_is_div = op[2] | op[3];

  // Signed divide works on magnitudes; 0x80000000 negates to itself as unsigned.
  assign w_a_mag = (op[2] & A[31]) ? (32'd0 - A) : A;
  assign w_b_mag = (op[2] & B[31]) ? (32'd0 - B) : B;

`ifdef MDU_DIV_ZERO_EARLY_EN
  assign w_early = w_is_div & (B == 32'd0);
`else
  assign w_early = 1'b0;
`endif

  // One 64-bit multiplier serves both MULT and MULTU via conditional sign extension.
  assign w_ma   = {{32{r_op[0] & r_a[31]}}, r_a};
  assign w_mb   = {{32{r_op[0] & r_b[31]}}, r_b};
  assign w_prod = w_ma * w_mb;

  // Restoring step: remainder shifts in the next dividend bit from r_quo's MSB.
  assign w_shift    = {r_rem, r_quo[31]};
  assign w_ge       = w_shift >= {1'b0, r_div};
  assign w_rem_next = w_ge ? (w_shift[31:0] - r_div) : w_shift[31:0];

  assign w_quo_fix = (r_op[2] & r_neg_q) ? (32'd0 - r_quo) : r_quo;
  assign w_rem_fix = (r_op[2] & r_neg_r) ? (32'd0 - r_rem) : r_rem;

  assign busy      = (r_state != c_IDLE);
  assign out_valid = ((r_state == c_ONE) | (r_state == c_FIX)) & ~cancel;
  assign result    = (out_valid & r_op[4]) ? r_hi :
                     (out_valid & r_op[5]) ? r_lo : 32'd0;
  assign hi        = r_hi;
  assign lo        = r_lo;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= c_IDLE;
      r_cnt   <= 5'd0;
      r_op    <= 8'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_quo   <= 32'd0;
      r_rem   <= 32'd0;
      r_div   <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_op  <= op;
            r_a   <= A;
            r_b   <= B;
            r_cnt <= 5'd0;
            if (w_is_div) begin
              // Early divide-by-zero preloads the FIX outputs: hi=A, lo=all ones.
              r_quo   <= w_early ? 32'hFFFF_FFFF : w_a_mag;
              r_rem   <= w_early ? A : 32'd0;
              r_div   <= w_b_mag;
              r_neg_q <= (A[31] ^ B[31]) & ~w_early;
              r_neg_r <= A[31] & ~w_early;
              r_state <= w_early ? c_FIX : c_DIV;
            end else begin
              r_state <= c_ONE;
            end
          end
        end
        c_ONE: begin
          r_state <= c_IDLE;
          if (!cancel) begin
            if (r_op[0] | r_op[1]) begin
              r_hi <= w_prod[63:32];
              r_lo <= w_prod[31:0];
            end
            if (r_op[6]) r_hi <= r_a;
            if (r_op[7]) r_lo <= r_a;
          end
        end
        c_DIV: begin
          if (cancel) begin
            r_state <= c_IDLE;
            r_cnt   <= 5'd0;
          end else begin
            r_rem <= w_rem_next;
            r_quo <= {r_quo[30:0], w_ge};
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) r_state <= c_FIX;
          end
        end
        default: begin
          r_state <= c_IDLE;
          if (!cancel && (r_op[2] | r_op[3])) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mdu_ctrl
// Description : Self-checking bench for ex_mdu_ctrl (vector table + sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mdu_ctrl;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        cancel;
  logic        busy;
  logic        out_valid;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  localparam logic [7:0] OP_MULT  = 8'h01;
  localparam logic [7:0] OP_MULTU = 8'h02;
  localparam logic [7:0] OP_DIV   = 8'h04;
  localparam logic [7:0] OP_DIVU  = 8'h08;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MFLO  = 8'h20;
  localparam logic [7:0] OP_MTHI  = 8'h40;
  localparam logic [7:0] OP_MTLO  = 8'h80;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          chk_hl;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [0:NVEC-1];

  int n_checks;
  int n_errors;

  ex_mdu_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .cancel    (cancel),
    .busy      (busy),
    .out_valid (out_valid),
    .result    (result),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op, then wait (bounded) for out_valid; returns latency in cycles
  // after the accept edge (-1 on timeout) and result; returns after HI/LO update.
  task automatic run_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 8'h00;
    lat = -1;
    res = 32'hDEAD_DEAD;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        res = result;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Accept a DIV/DIVU and return #1 after the accept edge (cycle T+1).
  task automatic start_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 8'h00;
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    int          cnt;

    n_checks = 0;
    n_errors = 0;
    resetn   = 1'b0;
    in_valid = 1'b0;
    op       = 8'h00;
    A        = 32'd0;
    B        = 32'd0;
    cancel   = 1'b0;

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,         1,  32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,         1,  32'd0,         32'h0000_0002, 32'hFFFF_FFFA, 1'b1};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         33, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1};
    vecs[3]  = '{OP_DIVU,  32'd100,       32'd7,         33, 32'd0,         32'd2,         32'd14,        1'b1};
    vecs[4]  = '{OP_MFLO,  32'h1111_1111, 32'h2222_2222, 1,  32'd14,        32'd2,         32'd14,        1'b1};
    vecs[5]  = '{OP_MFHI,  32'h3333_3333, 32'h4444_4444, 1,  32'd2,         32'd2,         32'd14,        1'b1};
    vecs[6]  = '{OP_MTHI,  32'h1234_5678, 32'd0,         1,  32'd0,         32'h1234_5678, 32'd14,        1'b1};
    vecs[7]  = '{OP_MFHI,  32'd0,         32'd0,         1,  32'h1234_5678, 32'h1234_5678, 32'd14,        1'b1};
    vecs[8]  = '{OP_MTLO,  32'hCAFE_BABE, 32'd5,         1,  32'd0,         32'h1234_5678, 32'hCAFE_BABE, 1'b1};
    vecs[9]  = '{OP_MFLO,  32'd0,         32'd0,         1,  32'hCAFE_BABE, 32'h1234_5678, 32'hCAFE_BABE, 1'b1};
    vecs[10] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0,         32'd0,         32'h8000_0000, 1'b1};
    vecs[11] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 33, 32'd0,         32'd1,         32'hFFFF_FFFD, 1'b1};
    vecs[12] = '{OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, 32'd0,         32'hFFFF_FFFF, 32'd3,         1'b1};
    vecs[13] = '{OP_DIV,   32'd5,         32'h8000_0000, 33, 32'd0,         32'd5,         32'd0,         1'b1};
    vecs[14] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,  32'd0,         32'd0,         32'd1,         1'b1};
    vecs[15] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,  32'd0,         32'hFFFF_FFFE, 32'd1,         1'b1};
    vecs[16] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         33, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b1};
`ifdef MDU_DIV_ZERO_EARLY_EN
    vecs[17] = '{OP_DIVU,  32'd9,         32'd0,         1,  32'd0,         32'd9,         32'hFFFF_FFFF, 1'b1};
`else
    vecs[17] = '{OP_DIVU,  32'd9,         32'd0,         33, 32'd0,         32'd0,         32'd0,         1'b0};
`endif

    // Reset state while resetn is held low.
    #2;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_result", i), res, vecs[i].res);
      if (vecs[i].chk_hl) begin
        chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
        chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      end
    end

    // Known HI/LO baseline for the cancel sequences.
    run_op(OP_MTHI, 32'hAAAA_5555, 32'd0, lat, res);
    run_op(OP_MTLO, 32'h5555_AAAA, 32'd0, lat, res);
    chk("base_hi", hi, 32'hAAAA_5555);
    chk("base_lo", lo, 32'h5555_AAAA);

    // DIVU busy/in_ready profile over T+1..T+33, idle at T+34.
    start_op(OP_DIVU, 32'd100, 32'd7);
    cnt = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (busy && !in_ready) cnt++;
      if (k < 33) begin
        @(posedge clk);
        #1;
      end
    end
    chk("divu_busy_cycles", 32'(cnt), 32'd33);
    chk("divu_out_valid_t33", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("divu_idle_t34", {30'd0, busy, in_ready}, 32'd1);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    run_op(OP_MTHI, 32'hAAAA_5555, 32'd0, lat, res);
    run_op(OP_MTLO, 32'h5555_AAAA, 32'd0, lat, res);

    // DIV 5/3 cancelled at T+10.
    start_op(OP_DIV, 32'd5, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(negedge clk);
    chk("cancel_div_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_div_idle_t11", {30'd0, busy, in_ready}, 32'd1);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("cancel_div_no_valid", 32'(cnt), 32'd0);
    chk("cancel_div_hi", hi, 32'hAAAA_5555);
    chk("cancel_div_lo", lo, 32'h5555_AAAA);

    // Cancel in the ONE cycle of an MTHI.
    start_op(OP_MTHI, 32'h0BAD_F00D, 32'd0);
    cancel = 1'b1;
    @(negedge clk);
    chk("cancel_one_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_one_busy", {31'd0, busy}, 32'd0);
    chk("cancel_one_hi", hi, 32'hAAAA_5555);

    // Cancel in the FIX cycle of a DIVU.
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (32) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(negedge clk);
    chk("cancel_fix_out_valid", {31'd0, out_valid}, 32'd0);
    chk("cancel_fix_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_fix_idle", {31'd0, busy}, 32'd0);
    chk("cancel_fix_hi", hi, 32'hAAAA_5555);
    chk("cancel_fix_lo", lo, 32'h5555_AAAA);

    // Non-one-hot op is ignored and leaves in_ready alone.
    @(negedge clk);
    in_valid = 1'b1;
    op = 8'h03;
    A = 32'd1;
    B = 32'd1;
    #1;
    chk("bad_op_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 8'h00;
    @(negedge clk);
    chk("bad_op_not_accepted", {31'd0, busy}, 32'd0);

    // Cancel blocks acceptance in IDLE.
    @(negedge clk);
    cancel = 1'b1;
    in_valid = 1'b1;
    op = OP_MTHI;
    A = 32'h0000_0001;
    #1;
    chk("cancel_idle_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    in_valid = 1'b0;
    op = 8'h00;
    @(negedge clk);
    chk("cancel_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("cancel_idle_hi", hi, 32'hAAAA_5555);

    // Asynchronous reset mid-DIV.
    start_op(OP_DIV, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_reset_hi", hi, 32'd0);
    chk("async_reset_lo", lo, 32'd0);
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid || busy) cnt++;
    end
    chk("post_reset_discarded", 32'(cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_mdu_ctrl.md
EX_MDU_CTRL -- requirements
Module: ex_mdu_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid  in  1  EX stage presents an MDU op.
REQ-004 SHALL have port in_ready  out  1  controller can accept an op.
REQ-005 SHALL have port op  in  8  one-hot: [0]MULT [1]MULTU [2]DIV [3]DIVU [4]MFHI [5]MFLO [6]MTHI [7]MTLO.
REQ-006 SHALL have ports A, B  in  32 each  rs and rt operands.
REQ-007 SHALL have port cancel  in  1  exception flush of the op in flight.
REQ-008 SHALL have port busy  out  1  op accepted and not yet completed; EX stalls on it.
REQ-009 SHALL have port out_valid  out  1  one-cycle completion pulse.
REQ-010 SHALL have port result  out  32  HI for MFHI, LO for MFLO, else 0.
REQ-011 SHALL have ports hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-012 SHALL implement FSM states IDLE, ONE, DIV, FIX; in_ready = (state==IDLE) & ~cancel.
REQ-013 SHALL accept an op when in_valid & in_ready; op sampled with A, B into internal registers.
REQ-014 SHALL go IDLE->ONE for MULT, MULTU, MFHI, MFLO, MTHI, MTLO; ONE->IDLE next cycle with out_valid=1.
REQ-015 SHALL in ONE write {hi,lo}=A*B (64-bit, signed for MULT, unsigned for MULTU); MTHI hi=A; MTLO lo=A; MFHI/MFLO leave HI/LO unchanged.
REQ-016 SHALL drive result in the out_valid cycle from HI/LO values before that cycle's write.
REQ-017 SHALL go IDLE->DIV for DIV/DIVU; DIV runs exactly 32 restoring iterations, 5-bit counter 0..31, one quotient bit per cycle, MSB first.
REQ-018 SHALL for DIV operate on magnitudes |A|, |B|; DIVU uses raw operands; |0x80000000| treated as unsigned 0x80000000.
REQ-019 SHALL go DIV->FIX when counter wraps 31->0; FIX negates quotient if A[31]^B[31] (DIV only), negates remainder if A[31] (DIV only), writes lo=quotient, hi=remainder, out_valid=1, then IDLE.
REQ-020 SHALL give DIV/DIVU latency: accept at cycle T, out_valid at T+33, new HI/LO visible T+34.
REQ-021 SHALL give 0x80000000 DIV 0xFFFFFFFF lo=0x80000000, hi=0; no overflow signalled.
REQ-022 SHALL assert busy whenever state!=IDLE.
REQ-023 SHALL on cancel in any non-IDLE state go to IDLE next cycle, no out_valid, HI/LO unchanged (including cancel in ONE or FIX cycle).
REQ-024 SHALL not accept an op in a cycle where cancel=1.
REQ-025 SHALL ignore op encodings not exactly one-hot: not accepted, in_ready unaffected.

Reset
REQ-026 SHALL on resetn=0 immediately force state=IDLE, counter=0, hi=0, lo=0, out_valid=0, result=0, busy=0.
REQ-027 SHALL on reset during DIV discard the operation; first cycle after release in_ready=1.

Configuration
REQ-028 SHALL honour macro MDU_DIV_ZERO_EARLY_EN.
REQ-029 SHALL with MDU_DIV_ZERO_EARLY_EN defined: DIV/DIVU with B==0 goes IDLE->FIX directly, out_valid at T+1, hi=A, lo=0xFFFFFFFF.
REQ-030 SHALL without it: B==0 runs full 32-iteration path, latency per REQ-020, HI/LO values unspecified (MIPS UNPREDICTABLE); bench checks only timing.

Verification
REQ-031 SHALL cover MULT A=0xFFFFFFFE, B=3 -> out_valid at T+1, hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same -> hi=0x2, lo=0xFFFFFFFA.
REQ-032 SHALL cover DIV A=0xFFFFFFF9(-7), B=2 -> busy T+1..T+33, out_valid T+33, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 SHALL cover DIVU A=100, B=7 then MFLO, MFHI -> result 14, then 2; in_ready low T+1..T+33.
REQ-034 SHALL cover DIV A=5, B=3, cancel at T+10 -> no out_valid, IDLE at T+11, hi/lo keep prior values.
REQ-035 SHALL cover MTHI A=0x12345678 then MFHI -> result 0x12345678; resetn low mid-DIV -> hi=lo=0 asynchronously.
REQ-036 SHALL cover DIVU A=9, B=0 -> with macro out_valid T+1, hi=9, lo=0xFFFFFFFF; without macro out_valid T+33.
